// File: rtl/fbw_arbiter_pkg.sv
// fbw_arbiter_pkg: shared types and constants for the frame-buffer write arbiter.
// State encodings, datapath widths, the bundled producer-side write interface
// and the owner-selection helper used by the arbiter top.
package fbw_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int ROW_W  = 6;
    localparam int COL_W  = 6;
    localparam int DATA_W = 24;
    localparam int WD_W   = 16;

    // One producer's view of the frame-buffer write interface.
    typedef struct packed {
        logic [ROW_W-1:0]  row_addr;
        logic              row_store;
        logic              row_swap;
        logic [DATA_W-1:0] data;
        logic [COL_W-1:0]  col_addr;
        logic              wren;
        logic              frame_swap;
    } fbw_port_t;

    // Round-robin pick: a lone requester wins; on a tie the port not served last wins.
    function automatic logic pick_owner(input logic req0, input logic req1, input logic last);
        logic winner;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
        return winner;
    endfunction

    // Any strobe from the owner counts as forward progress for the watchdog.
    function automatic logic port_active(input fbw_port_t p);
        return p.wren | p.row_store | p.row_swap | p.frame_swap;
    endfunction

endpackage

// File: rtl/fbw_arbiter_wdog.sv
// fbw_arbiter_wdog: idle-owner watchdog. Counts cycles while the grant is held
// without any owner activity and flags expiry on the TIMEOUT-th idle cycle.
module fbw_arbiter_wdog
    import fbw_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] count_reg;
    logic [WD_W-1:0] count_next;

    // Counter value equals the number of idle cycles already seen, so the
    // current idle cycle is the TIMEOUT-th one when the count hits LIMIT.
    assign expired = run && !kick && (count_reg == LIMIT);

    // Next count: restart whenever not granted, on activity, or after firing.
    always_comb begin
        count_next = count_reg;
        if (!run || kick || expired) begin
            count_next = '0;
        end else begin
            count_next = count_reg + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/fbw_arbiter.sv
// fbw_arbiter: shares one frame-buffer write interface between two producers.
// A port keeps the grant for a whole frame (until its own frame_swap); ties are
// broken round-robin. Downstream signals are a zero-latency mux on the
// registered grant. The idle-owner watchdog is compiled in only when
// FBW_ARBITER_WATCHDOG_EN is defined; otherwise wd_expired is tied low.
module fbw_arbiter
    import fbw_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    output logic              m0_gnt,
    output logic              m1_gnt,
    input  logic [ROW_W-1:0]  m0_row_addr,
    input  logic              m0_row_store,
    input  logic              m0_row_swap,
    input  logic [DATA_W-1:0] m0_data,
    input  logic [COL_W-1:0]  m0_col_addr,
    input  logic              m0_wren,
    input  logic              m0_frame_swap,
    output logic              m0_row_rdy,
    output logic              m0_frame_rdy,
    input  logic [ROW_W-1:0]  m1_row_addr,
    input  logic              m1_row_store,
    input  logic              m1_row_swap,
    input  logic [DATA_W-1:0] m1_data,
    input  logic [COL_W-1:0]  m1_col_addr,
    input  logic              m1_wren,
    input  logic              m1_frame_swap,
    output logic              m1_row_rdy,
    output logic              m1_frame_rdy,
    output logic [ROW_W-1:0]  fbw_row_addr,
    output logic              fbw_row_store,
    output logic              fbw_row_swap,
    output logic [DATA_W-1:0] fbw_data,
    output logic [COL_W-1:0]  fbw_col_addr,
    output logic              fbw_wren,
    output logic              frame_swap,
    input  logic              fbw_row_rdy,
    input  logic              frame_rdy,
    output logic              wd_expired
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
        $error("fbw_arbiter: TIMEOUT must lie in 2..65535");
    end

    state_t    state_reg, state_next;
    logic      owner_reg, owner_next;
    logic      last_reg, last_next;
    logic [1:0] gnt_reg, gnt_next;

    fbw_port_t port_in [2];
    fbw_port_t owner_sel;
    fbw_port_t out_bus;
    logic      wd_fire;

    logic [1:0] row_rdy_vec;
    logic [1:0] frame_rdy_vec;

    assign port_in[0] = {m0_row_addr, m0_row_store, m0_row_swap, m0_data,
                         m0_col_addr, m0_wren, m0_frame_swap};
    assign port_in[1] = {m1_row_addr, m1_row_store, m1_row_swap, m1_data,
                         m1_col_addr, m1_wren, m1_frame_swap};

    assign owner_sel = port_in[owner_reg];

`ifdef FBW_ARBITER_WATCHDOG_EN
    logic owner_kick;
    assign owner_kick = port_active(owner_sel);

    fbw_arbiter_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state_reg == ST_GRANT),
        .kick    (owner_kick),
        .expired (wd_fire)
    );
`else
    assign wd_fire = 1'b0;
`endif

    assign wd_expired = wd_fire;

    // Next-state logic: pick an owner from idle, hold until its frame_swap or
    // watchdog revoke, then spend one turnaround cycle before arbitrating again.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        gnt_next   = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_next = ST_GRANT;
                    owner_next = pick_owner(m0_req, m1_req, last_reg);
                    last_next  = owner_next;
                end
            end
            ST_GRANT: begin
                if (owner_sel.frame_swap || wd_fire) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (state_next == ST_GRANT) begin
            gnt_next = owner_next ? 2'b10 : 2'b01;
        end
    end

    // State, owner, round-robin pointer and grant registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            gnt_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            gnt_reg   <= gnt_next;
        end
    end

    // Downstream mux: owner's signals pass through only while granted.
    always_comb begin
        out_bus = '0;
        if (state_reg == ST_GRANT) begin
            out_bus = owner_sel;
        end
    end

    assign fbw_row_addr  = out_bus.row_addr;
    assign fbw_row_store = out_bus.row_store;
    assign fbw_row_swap  = out_bus.row_swap;
    assign fbw_data      = out_bus.data;
    assign fbw_col_addr  = out_bus.col_addr;
    assign fbw_wren      = out_bus.wren;
    assign frame_swap    = out_bus.frame_swap;

    // Ready signals reach only the port holding the grant.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdy
        assign row_rdy_vec[gi]   = gnt_reg[gi] & fbw_row_rdy;
        assign frame_rdy_vec[gi] = gnt_reg[gi] & frame_rdy;
    end

    assign m0_gnt       = gnt_reg[0];
    assign m1_gnt       = gnt_reg[1];
    assign m0_row_rdy   = row_rdy_vec[0];
    assign m0_frame_rdy = frame_rdy_vec[0];
    assign m1_row_rdy   = row_rdy_vec[1];
    assign m1_frame_rdy = frame_rdy_vec[1];

endmodule

// File: tb/tb_fbw_arbiter.sv
// tb_fbw_arbiter: directed scenarios plus randomized traffic for fbw_arbiter,
// checked every cycle against a frame-ownership reference model.
module tb_fbw_arbiter;

    localparam int TIMEOUT_TB = 16;
`ifdef FBW_ARBITER_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, row_store, row_swap, wren, fsw;
    logic [5:0]  row_addr [2];
    logic [5:0]  col_addr [2];
    logic [23:0] data [2];
    logic        fbw_row_rdy, frame_rdy;

    logic        m0_gnt, m1_gnt, m0_row_rdy, m0_frame_rdy, m1_row_rdy, m1_frame_rdy;
    logic [5:0]  fbw_row_addr, fbw_col_addr;
    logic [23:0] fbw_data;
    logic        fbw_row_store, fbw_row_swap, fbw_wren, frame_swap, wd_expired;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the buffer, turnaround cycles left, last served,
    // consecutive idle owner cycles so far.
    int mdl_owner, mdl_gap, mdl_last, mdl_quiet;

    int cnt_wren, cnt_store, cnt_fs, cnt_wd;
    logic obs_wd;

    always #5 clk = ~clk;

    fbw_arbiter #(.TIMEOUT(TIMEOUT_TB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m1_req(req[1]),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_row_addr(row_addr[0]), .m0_row_store(row_store[0]), .m0_row_swap(row_swap[0]),
        .m0_data(data[0]), .m0_col_addr(col_addr[0]), .m0_wren(wren[0]), .m0_frame_swap(fsw[0]),
        .m0_row_rdy(m0_row_rdy), .m0_frame_rdy(m0_frame_rdy),
        .m1_row_addr(row_addr[1]), .m1_row_store(row_store[1]), .m1_row_swap(row_swap[1]),
        .m1_data(data[1]), .m1_col_addr(col_addr[1]), .m1_wren(wren[1]), .m1_frame_swap(fsw[1]),
        .m1_row_rdy(m1_row_rdy), .m1_frame_rdy(m1_frame_rdy),
        .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store), .fbw_row_swap(fbw_row_swap),
        .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
        .frame_swap(frame_swap), .fbw_row_rdy(fbw_row_rdy), .frame_rdy(frame_rdy),
        .wd_expired(wd_expired)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_port(input int p);
        row_store[p] = 1'b0; row_swap[p] = 1'b0; wren[p] = 1'b0; fsw[p] = 1'b0;
        row_addr[p] = '0; col_addr[p] = '0; data[p] = '0;
    endtask

    // One clock: compare all outputs to the model, then advance the model at the edge.
    task automatic cycle();
        logic [63:0] got, exp;
        logic act, ewd;
        int o, w;
        #3;
        o = mdl_owner;
        ewd = 1'b0;
        act = 1'b0;
        exp = '0;
        if (o >= 0) begin
            act = wren[o] | row_store[o] | row_swap[o] | fsw[o];
            ewd = WD_ON && !act && (mdl_quiet + 1 == TIMEOUT_TB);
            exp = {17'd0, o == 0, o == 1, (o == 0) && fbw_row_rdy, (o == 0) && frame_rdy,
                   (o == 1) && fbw_row_rdy, (o == 1) && frame_rdy,
                   row_addr[o], row_store[o], row_swap[o], data[o], col_addr[o],
                   wren[o], fsw[o], ewd};
        end
        got = {17'd0, m0_gnt, m1_gnt, m0_row_rdy, m0_frame_rdy, m1_row_rdy, m1_frame_rdy,
               fbw_row_addr, fbw_row_store, fbw_row_swap, fbw_data, fbw_col_addr,
               fbw_wren, frame_swap, wd_expired};
        check_eq("cycle", got, exp);
        obs_wd = wd_expired;
        cnt_wren += int'(fbw_wren);
        cnt_store += int'(fbw_row_store);
        cnt_fs += int'(frame_swap);
        cnt_wd += int'(wd_expired);
        @(posedge clk);
        if (rst) begin
            mdl_owner = -1; mdl_gap = 0; mdl_last = 1; mdl_quiet = 0;
        end else if (o >= 0) begin
            if (fsw[o] || ewd) begin
                mdl_owner = -1; mdl_gap = 1; mdl_quiet = 0;
            end else begin
                mdl_quiet = act ? 0 : mdl_quiet + 1;
            end
        end else if (mdl_gap > 0) begin
            mdl_gap--;
        end else if (req != 2'b00) begin
            w = (req == 2'b11) ? 1 - mdl_last : (req[1] ? 1 : 0);
            mdl_owner = w; mdl_last = w; mdl_quiet = 0;
        end
        #1;
    endtask

    task automatic wait_owner(input int p, input string tag);
        int n = 0;
        while (mdl_owner != p && n < 20) begin
            cycle();
            n++;
        end
        check_eq(tag, {62'd0, m1_gnt, m0_gnt}, (p == 1) ? 64'd2 : 64'd1);
    endtask

    // Cycles from the cycle after a release until some grant shows up.
    task automatic measure_gap(output int n);
        n = 0;
        while ({m1_gnt, m0_gnt} == 2'b00 && n < 20) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n, g;
        rst = 1'b1; req = 2'b00; fbw_row_rdy = 1'b0; frame_rdy = 1'b0;
        clear_port(0); clear_port(1);
        mdl_owner = -1; mdl_gap = 0; mdl_last = 1; mdl_quiet = 0;
        cnt_wren = 0; cnt_store = 0; cnt_fs = 0; cnt_wd = 0; obs_wd = 1'b0;
        @(posedge clk); #1;

        // Reset held with both requests: everything stays low; port 0 wins first.
        req = 2'b11;
        repeat (3) cycle();
        check_eq("rst_outs", {58'd0, m0_gnt, m1_gnt, fbw_wren, fbw_row_store, frame_swap, wd_expired}, 64'd0);
        rst = 1'b0;
        cycle();
        check_eq("rst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd1);

        // Port 0 closes its frame, port 1 then runs a full 64x64 frame.
        req = 2'b00; fsw[0] = 1'b1; cycle(); fsw[0] = 1'b0;
        req[1] = 1'b1;
        wait_owner(1, "sf_gnt");
        cnt_wren = 0; cnt_store = 0; cnt_fs = 0;
        fbw_row_rdy = 1'b1;
        for (int r = 0; r < 64; r++) begin
            row_addr[1] = 6'(r);
            for (int c = 0; c < 64; c++) begin
                wren[1] = 1'b1; col_addr[1] = 6'(c); data[1] = 24'($urandom);
                cycle();
            end
            wren[1] = 1'b0; row_store[1] = 1'b1;
            cycle();
            row_store[1] = 1'b0;
        end
        fsw[1] = 1'b1; req[1] = 1'b0;
        cycle();
        fsw[1] = 1'b0;
        check_eq("sf_gnt_drop", {63'd0, m1_gnt}, 64'd0);
        check_eq("sf_wren_cnt", 64'(cnt_wren), 64'd4096);
        check_eq("sf_store_cnt", 64'(cnt_store), 64'd64);
        check_eq("sf_fs_cnt", 64'(cnt_fs), 64'd1);

        // Both ports request for four frames: grants alternate, 3-cycle handover.
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            measure_gap(n);
            if (i > 0) check_eq("rr_gap", 64'(n), 64'd2);
            check_eq("rr_gnt", {62'd0, m1_gnt, m0_gnt}, (i % 2 == 1) ? 64'd2 : 64'd1);
            g = (m1_gnt === 1'b1) ? 1 : 0;
            repeat (3) begin
                wren[g] = 1'b1; data[g] = 24'($urandom); col_addr[g] = 6'($urandom);
                cycle();
            end
            wren[g] = 1'b0; fsw[g] = 1'b1;
            cycle();
            fsw[g] = 1'b0;
        end

        // Port 0 owns; port 1 hammers every strobe and must have no effect.
        wait_owner(0, "iso_gnt");
        clear_port(0);
        frame_rdy = 1'b1;
        wren[1] = 1'b1; data[1] = 24'hABCDEF; row_store[1] = 1'b1; row_swap[1] = 1'b1; fsw[1] = 1'b1;
        repeat (6) begin
            cycle();
            check_eq("iso_strobes", {59'd0, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap, m1_gnt}, 64'd0);
            check_eq("iso_rdy", {62'd0, m1_row_rdy, m1_frame_rdy}, 64'd0);
            check_eq("iso_data", {40'd0, fbw_data}, 64'd0);
        end
        clear_port(1);
        frame_rdy = 1'b0;

        // Mid-frame reset during row 10 aborts the frame silently.
        req = 2'b01;
        cnt_fs = 0;
        for (int k = 0; k < 44; k++) begin
            row_addr[0] = 6'(k / 4); col_addr[0] = 6'(k % 4);
            wren[0] = 1'b1; data[0] = 24'($urandom);
            if (k == 42) rst = 1'b1;
            cycle();
            if (k == 42) break;
        end
        rst = 1'b0;
        check_eq("mfr_outs", {58'd0, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap, m0_gnt, m1_gnt}, 64'd0);
        cycle();
        clear_port(0);
        check_eq("mfr_no_fs", 64'(cnt_fs), 64'd0);

        // Owner stalls after 5 writes while port 1 waits.
        req = 2'b11;
        wait_owner(0, "wd_gnt");
        repeat (5) begin
            wren[0] = 1'b1; data[0] = 24'($urandom);
            cycle();
        end
        wren[0] = 1'b0;
        cnt_wd = 0;
`ifdef FBW_ARBITER_WATCHDOG_EN
        n = 0;
        obs_wd = 1'b0;
        while (!obs_wd && n < 40) begin
            cycle();
            n++;
        end
        check_eq("wd_idle_cycles", 64'(n), 64'd16);
        check_eq("wd_revoke", {63'd0, m0_gnt}, 64'd0);
        measure_gap(n);
        check_eq("wd_gap", 64'(n), 64'd2);
        check_eq("wd_next_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd2);
        fsw[1] = 1'b1; cycle(); fsw[1] = 1'b0;
`else
        repeat (40) cycle();
        check_eq("hold_gnt", {63'd0, m0_gnt}, 64'd1);
        check_eq("wd_off", 64'(cnt_wd), 64'd0);
        fsw[0] = 1'b1; cycle(); fsw[0] = 1'b0;
`endif

        // Randomized traffic in blocks of varying producer activity.
        for (int b = 0; b < 12; b++) begin
            int d;
            d = $urandom_range(0, 3);
            for (int k = 0; k < 250; k++) begin
                for (int p = 0; p < 2; p++) begin
                    req[p] = ($urandom % 4) != 0;
                    wren[p] = ($urandom % 4) < d;
                    row_store[p] = (d > 0) && (($urandom % 16) == 0);
                    row_swap[p] = (d > 0) && (($urandom % 16) == 0);
                    fsw[p] = ($urandom % 24) == 0;
                    data[p] = 24'($urandom);
                    row_addr[p] = 6'($urandom);
                    col_addr[p] = 6'($urandom);
                end
                fbw_row_rdy = $urandom % 2 == 1;
                frame_rdy = $urandom % 2 == 1;
                rst = ($urandom % 500) == 0;
                cycle();
            end
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
